// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the multicycle CPU datapath blocks.
//   state_div_t : divider control states (IDLE, RUN, FIX)
//   DATA_W      : native datapath width of the CPU
//   DIV_CNT_W   : width of the divider's bit counter at DATA_W
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int DATA_W    = 32;
  localparam int DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_div_t;

endpackage

// File: rtl/twos_abs.sv
// ---------------------------------------------------------------------------
// twos_abs
// Two's-complement magnitude of a signed operand.
//   value : WIDTH-bit signed input
//   mag   : WIDTH+1-bit unsigned magnitude (extra bit so |INT_MIN| is exact)
//   neg   : sign bit of value
// ---------------------------------------------------------------------------
module twos_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH:0]   mag,
  output logic             neg
);

  logic [WIDTH:0] value_ext;

  // Sign-extend by one bit first so negating INT_MIN does not wrap.
  assign value_ext = {value[WIDTH-1], value};
  assign neg       = value[WIDTH-1];
  assign mag       = neg ? (~value_ext + (WIDTH+1)'(1)) : value_ext;

endmodule

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Sequential signed restoring divider (MIPS div semantics) for HI/LO.
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-high; returns to IDLE, clears outputs
//   start    : request, sampled only in IDLE
//   dividend : signed operand A
//   divisor  : signed operand B
//   hi       : remainder (sign of dividend), registered
//   lo       : quotient (truncated toward zero), registered
//   div_zero : one-cycle pulse, divisor was zero at start
//   done     : one-cycle pulse, hi/lo just updated
//   busy     : high while in RUN or FIX
// Latency is a constant 34 edges from the accepting edge to done.
// ---------------------------------------------------------------------------
module seq_divider
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero,
  output logic             done,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_div_t state, state_next;

  logic [WIDTH:0]   dvd_mag;
  logic [WIDTH:0]   dvs_mag;
  logic             dvd_neg;
  logic             dvs_neg;

  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   dvs_q;
  logic             sign_q;
  logic             sign_r;
  logic [CNT_W-1:0] count;

  logic             divisor_zero;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;

  twos_abs #(.WIDTH(WIDTH)) u_abs_dividend (
    .value (dividend),
    .mag   (dvd_mag),
    .neg   (dvd_neg)
  );

  twos_abs #(.WIDTH(WIDTH)) u_abs_divisor (
    .value (divisor),
    .mag   (dvs_mag),
    .neg   (dvs_neg)
  );

  assign divisor_zero = (divisor == '0);
  assign busy         = (state == RUN) || (state == FIX);

  // One restoring step: the quotient register still holds the unconsumed
  // dividend bits in its upper part, so its MSB is the next bit to bring
  // into the partial remainder.
  assign rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign rem_diff  = rem_shift - dvs_q;
  assign rem_ge    = (rem_shift >= dvs_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && !divisor_zero) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (count == '0) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem      <= '0;
      quo      <= '0;
      dvs_q    <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor_zero) begin
              div_zero <= 1'b1;
            end else begin
              rem    <= '0;
              // |dividend| always fits in WIDTH unsigned bits.
              quo    <= WIDTH'(dvd_mag);
              dvs_q  <= dvs_mag;
              sign_q <= dvd_neg ^ dvs_neg;
              sign_r <= dvd_neg;
              count  <= CNT_W'(WIDTH - 1);
            end
          end
        end
        RUN: begin
          rem <= rem_ge ? rem_diff : rem_shift;
          quo <= {quo[WIDTH-2:0], rem_ge};
          if (count != '0) begin
            count <= count - 1'b1;
          end
        end
        FIX: begin
          // INT_MIN / -1 falls out naturally: negating 2^(WIDTH-1) and
          // truncating gives INT_MIN back.
          lo   <= sign_q ? (~quo + WIDTH'(1)) : quo;
          hi   <= sign_r ? WIDTH'(~rem + (WIDTH+1)'(1)) : WIDTH'(rem);
          done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
// Directed and randomized checks of seq_divider against a plain arithmetic
// model of signed division (truncate toward zero, remainder takes the
// dividend's sign), computed with 64-bit integers.
// ---------------------------------------------------------------------------
module tb_seq_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;
  logic        done;
  logic        busy;

  int checks;
  int errors;

  logic [31:0] model_hi;
  logic [31:0] model_lo;

  seq_divider #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero),
    .done     (done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference division: plain 64-bit arithmetic, so INT_MIN / -1 gives
  // +2^31, which truncates to 0x80000000 as required.
  task automatic model_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
    longint la;
    longint lb;
    longint lq;
    longint lr;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    lq = la / lb;
    lr = la % lb;
    q  = lq[31:0];
    r  = lr[31:0];
  endtask

  // Launches one operation and checks it through to the done cycle.
  // b2b: start is raised in the current cycle (caller is sitting in a done
  // cycle) instead of after the next falling edge.
  // disturb: operands and start are scrambled while the divider runs.
  task automatic apply_stimulus(input string tag, input logic [31:0] a,
                                input logic [31:0] b, input bit b2b,
                                input bit disturb);
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    if (!b2b) @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (b == 32'd0) begin
      check_output({tag, " div_zero pulse"}, 32'(div_zero), 32'd1);
      check_output({tag, " busy stays low"}, 32'(busy), 32'd0);
      check_output({tag, " no done"}, 32'(done), 32'd0);
      @(negedge clk);
      check_output({tag, " div_zero single"}, 32'(div_zero), 32'd0);
      check_output({tag, " hi held"}, hi, model_hi);
      check_output({tag, " lo held"}, lo, model_lo);
    end else begin
      model_div(a, b, exp_q, exp_r);
      check_output({tag, " busy rises"}, 32'(busy), 32'd1);
      for (int i = 0; i < 32; i++) begin
        if (disturb && i < 30) begin
          dividend = $urandom;
          divisor  = $urandom;
          start    = ~start;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
      check_output({tag, " no early done"}, 32'(done), 32'd0);
      check_output({tag, " busy in FIX"}, 32'(busy), 32'd1);
      @(negedge clk);
      check_output({tag, " done"}, 32'(done), 32'd1);
      check_output({tag, " busy falls"}, 32'(busy), 32'd0);
      check_output({tag, " lo"}, lo, exp_q);
      check_output({tag, " hi"}, hi, exp_r);
      model_hi = exp_r;
      model_lo = exp_q;
    end
  endtask

  initial begin
    int done_seen;
    logic [31:0] ra;
    logic [31:0] rb;

    checks   = 0;
    errors   = 0;
    model_hi = '0;
    model_lo = '0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    reset    = 1'b1;

    $display("[TB] reset values");
    repeat (2) @(negedge clk);
    check_output("reset hi", hi, 32'd0);
    check_output("reset lo", lo, 32'd0);
    check_output("reset done", 32'(done), 32'd0);
    check_output("reset div_zero", 32'(div_zero), 32'd0);
    check_output("reset busy", 32'(busy), 32'd0);
    reset = 1'b0;

    $display("[TB] basic and sign cases");
    apply_stimulus("100/7", 32'd100, 32'd7, 1'b0, 1'b0);
    @(negedge clk);
    check_output("100/7 done single", 32'(done), 32'd0);
    apply_stimulus("-7/2", -32'sd7, 32'd2, 1'b0, 1'b0);
    check_output("-7/2 lo const", lo, 32'hFFFF_FFFD);
    check_output("-7/2 hi const", hi, 32'hFFFF_FFFF);
    apply_stimulus("7/-2", 32'd7, -32'sd2, 1'b0, 1'b0);
    check_output("7/-2 hi const", hi, 32'd1);
    apply_stimulus("-7/-2", -32'sd7, -32'sd2, 1'b0, 1'b0);
    check_output("-7/-2 lo const", lo, 32'd3);

    $display("[TB] divide by zero and INT_MIN wrap");
    apply_stimulus("5/0", 32'd5, 32'd0, 1'b0, 1'b0);
    apply_stimulus("INT_MIN/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_output("INT_MIN/-1 lo const", lo, 32'h8000_0000);
    check_output("INT_MIN/-1 hi const", hi, 32'd0);
    apply_stimulus("INT_MIN/3", 32'h8000_0000, 32'd3, 1'b0, 1'b0);

    $display("[TB] robustness");
    apply_stimulus("disturbed 1234/-56", 32'd1234, -32'sd56, 1'b0, 1'b1);
    @(negedge clk);
    check_output("disturbed no relaunch busy", 32'(busy), 32'd0);
    check_output("disturbed no relaunch done", 32'(done), 32'd0);
    apply_stimulus("b2b first 999/10", 32'd999, 32'd10, 1'b0, 1'b0);
    apply_stimulus("b2b second -1000/33", -32'sd1000, 32'd33, 1'b1, 1'b0);

    $display("[TB] reset mid-run");
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check_output("pre-abort busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_output("abort busy", 32'(busy), 32'd0);
    check_output("abort hi", hi, 32'd0);
    check_output("abort lo", lo, 32'd0);
    check_output("abort done", 32'(done), 32'd0);
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check_output("abort never done", 32'(done_seen), 32'd0);
    apply_stimulus("after abort 100/7", 32'd100, 32'd7, 1'b0, 1'b0);

    $display("[TB] random operands");
    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(0, 15)) - 32'd8;
        1: rb = $urandom;
        2: rb = 32'($urandom_range(1, 1000));
        default: rb = 32'd0 - 32'($urandom_range(1, 1000));
      endcase
      apply_stimulus($sformatf("rand%0d", n), ra, rb, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential signed 32-bit divider feeding the multicycle CPU's HI/LO datapath: the control unit pulses `start` with A/B register contents and waits for `done` before loading HI (remainder) and LO (quotient). The algorithm is restoring division, one quotient bit per cycle. It reports divide-by-zero separately so the control unit can take the exception path instead of waiting.

## Interface
- `WIDTH`, default 32: operand/result width. The CPU always instantiates 32.
- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; forces IDLE and clears all outputs
- `start`  in  1  request; sampled only in IDLE
- `dividend`  in  WIDTH  signed operand (A register)
- `divisor`  in  WIDTH  signed operand (B register)
- `hi`  out  WIDTH  remainder, registered
- `lo`  out  WIDTH  quotient, registered
- `div_zero`  out  1  one-cycle pulse: divisor was zero at start
- `done`  out  1  one-cycle pulse: `hi`/`lo` just updated
- `busy`  out  1  high in RUN and FIX

## Operation
- States: IDLE, RUN, FIX.
- IDLE, `start`=1, `divisor`=0:
  - pulse `div_zero`, stay IDLE.
  - `hi`/`lo` hold; `done` not asserted.
- IDLE, `start`=1, `divisor`≠0:
  - latch |dividend| and |divisor| (two's-complement magnitude, WIDTH+1-bit internal to cover INT_MIN).
  - latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - clear the partial remainder, load counter = WIDTH-1, go RUN.
- RUN, each cycle:
  - shift {rem, quo} left 1, injecting the next dividend magnitude bit.
  - trial subtract divisor magnitude from rem; if non-negative, keep the difference and set quotient bit to 1, else restore and set it to 0.
  - on counter = 0 go FIX, else decrement.
- FIX:
  - `lo` = sign_q ? −quo : quo; `hi` = sign_r ? −rem : rem (both truncated to WIDTH).
  - pulse `done`, go IDLE.
- Semantics are MIPS `div`: the quotient truncates toward zero and the remainder takes the dividend's sign.
- INT_MIN / −1 wraps: `lo`=0x80000000, `hi`=0. No overflow flag.
- Operands are captured at start. Changes on `dividend`/`divisor` during RUN/FIX are ignored.
- `start` during RUN/FIX is ignored and not queued.

## Timing
- Reset values: `hi`=0, `lo`=0, `div_zero`=0, `done`=0, `busy`=0, state IDLE, counter 0.
- Start accepted at edge E0. RUN occupies edges E1..E32, FIX is edge E33.
- `hi`/`lo` are valid and `done`=1 in the cycle after E33: 34-edge latency, constant and independent of operand values.
- `busy` is high from after E0 through the cycle after E32 and low again with `done`.
- Divide-by-zero: `div_zero`=1 for the single cycle after E0. `busy` never rises.
- Back-to-back: `start` high in the `done` cycle is accepted (state is IDLE then). `hi`/`lo` hold the previous result until the next FIX.
- Reset mid-RUN/FIX: asynchronous abort, immediate return to reset values, no `done`.

## Structure
- Shared package `cpu_pkg` holds:
  - the state encoding typedef (IDLE=2'b00, RUN=2'b01, FIX=2'b10)
  - `DATA_W`=32
  - the counter width constant `DIV_CNT_W`=5
- One natural combinational sub-module, `twos_abs`: WIDTH in, WIDTH+1 magnitude out, plus a sign bit. It is reused for both operands.
- Conditional negation in FIX is inline; no further hierarchy.

## Test plan
- Reset:
  - Assert `reset` mid-RUN on a 100/7 operation → all outputs 0 immediately.
  - `done` never pulses; a new `start` is accepted after deassertion.
- 100 / 7 → on the 34th edge after start, `lo`=14, `hi`=2, `done` pulses for 1 cycle, `busy` falls the same cycle.
- Signs: −7/2 → `lo`=−3, `hi`=−1; 7/−2 → `lo`=−3, `hi`=1; −7/−2 → `lo`=3, `hi`=−1.
- Divide-by-zero and INT_MIN wrap:
  - 5/0 → `div_zero` for 1 cycle, `busy`=0, `hi`/`lo` unchanged from the previous result.
  - 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Robustness:
  - Toggle operands and `start` during RUN → result matches the operands captured at E0, and no second operation is launched.
  - `start` held in the `done` cycle → second result is produced 34 edges later.
